ps2_key_sequencer: RTL and testbench

Sequences raw PS/2 scan codes into a stream of ASCII characters for the typewriter display path. Sits between the PS/2 receiver (byte + done tick) and the character consumer (text buffer / VGA writer). Owns the make/break/extended protocol state, shift and caps-lock tracking, and case folding. Drives the `key2ascii` translator and queues results in a small FIFO with a pop handshake.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/char_fifo.sv | 60 ++++++
 rtl/key2ascii.sv | 41 ++++
 rtl/ps2_key_sequencer.sv | 87 ++++++++
 tb/tb_ps2_key_sequencer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, ASCII markers and protocol state type for the PS/2 key path.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK       = 8'hF0;
  localparam logic [7:0] SC_EXT         = 8'hE0;
  localparam logic [7:0] SC_LSHIFT      = 8'h12;
  localparam logic [7:0] SC_RSHIFT      = 8'h59;
  localparam logic [7:0] SC_CAPS        = 8'h58;
  localparam logic [7:0] ASCII_UNMAPPED = 8'h2A;

  typedef enum logic [1:0] {
    StIdle,
    StBreak,
    StExt,
    StExtBreak
  } ps2_state_e;

  function automatic logic is_upper_letter(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

endpackage

// File: rtl/char_fifo.sv
// Small character FIFO; head output holds the last head value once drained.
module char_fifo #(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       valid_o,
  output logic       overflow_o
);

  localparam int unsigned Depth = 2 ** FIFO_AW;

  logic [7:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [7:0]         last_q;
  logic               overflow_q;
  logic               empty, full, pop_en, push_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == Depth[FIFO_AW:0]);
  assign pop_en  = pop_i && !empty;
  // A full FIFO still accepts a push when the same edge frees a slot.
  assign push_en = push_i && (!full || pop_en);

  always_comb begin
    count_d = count_q;
    if (push_en && !pop_en) count_d = count_q + 1'b1;
    else if (pop_en && !push_en) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= 8'h00;
      overflow_q <= 1'b0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (!empty)  last_q   <= mem_q[rd_ptr_q];
      count_q    <= count_d;
      overflow_q <= push_i && full && !pop_en;
    end
  end

  assign head_o     = empty ? last_q : mem_q[rd_ptr_q];
  assign valid_o    = !empty;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/key2ascii.sv
// Combinational scan-code (set 2) to ASCII lookup; letters come out uppercase.
module key2ascii
  import ps2_pkg::*;
(
  input  logic [7:0] key_code,
  output logic [7:0] ascii_code
);

  always_comb begin
    ascii_code = ASCII_UNMAPPED;
    case (key_code)
      8'h45: ascii_code = 8'h30;  8'h16: ascii_code = 8'h31;
      8'h1E: ascii_code = 8'h32;  8'h26: ascii_code = 8'h33;
      8'h25: ascii_code = 8'h34;  8'h2E: ascii_code = 8'h35;
      8'h36: ascii_code = 8'h36;  8'h3D: ascii_code = 8'h37;
      8'h3E: ascii_code = 8'h38;  8'h46: ascii_code = 8'h39;
      8'h1C: ascii_code = 8'h41;  8'h32: ascii_code = 8'h42;
      8'h21: ascii_code = 8'h43;  8'h23: ascii_code = 8'h44;
      8'h24: ascii_code = 8'h45;  8'h2B: ascii_code = 8'h46;
      8'h34: ascii_code = 8'h47;  8'h33: ascii_code = 8'h48;
      8'h43: ascii_code = 8'h49;  8'h3B: ascii_code = 8'h4A;
      8'h42: ascii_code = 8'h4B;  8'h4B: ascii_code = 8'h4C;
      8'h3A: ascii_code = 8'h4D;  8'h31: ascii_code = 8'h4E;
      8'h44: ascii_code = 8'h4F;  8'h4D: ascii_code = 8'h50;
      8'h15: ascii_code = 8'h51;  8'h2D: ascii_code = 8'h52;
      8'h1B: ascii_code = 8'h53;  8'h2C: ascii_code = 8'h54;
      8'h3C: ascii_code = 8'h55;  8'h2A: ascii_code = 8'h56;
      8'h1D: ascii_code = 8'h57;  8'h22: ascii_code = 8'h58;
      8'h35: ascii_code = 8'h59;  8'h1A: ascii_code = 8'h5A;
      8'h0E: ascii_code = 8'h60;  8'h4E: ascii_code = 8'h2D;
      8'h55: ascii_code = 8'h3D;  8'h54: ascii_code = 8'h5B;
      8'h5B: ascii_code = 8'h5D;  8'h5D: ascii_code = 8'h5C;
      8'h4C: ascii_code = 8'h3B;  8'h52: ascii_code = 8'h27;
      8'h41: ascii_code = 8'h2C;  8'h49: ascii_code = 8'h2E;
      8'h4A: ascii_code = 8'h2F;  8'h29: ascii_code = 8'h20;
      8'h5A: ascii_code = 8'h0D;  8'h66: ascii_code = 8'h08;
      default: ascii_code = ASCII_UNMAPPED;
    endcase
  end

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 make/break/extended protocol tracking, shift/caps case folding, queued ASCII output.
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] scan_code,
  input  logic       scan_done_tick,
  input  logic       char_rd,
  output logic [7:0] char_data,
  output logic       char_valid,
  output logic       caps_lock,
  output logic       overflow
);

  ps2_state_e state_q, state_d;
  logic       shift_l_q, shift_l_d, shift_r_q, shift_r_d, caps_q, caps_d;
  logic [7:0] ascii, push_data;
  logic       push, upper;

  key2ascii u_key2ascii (
    .key_code   (scan_code),
    .ascii_code (ascii)
  );

  assign upper     = (shift_l_q | shift_r_q) ^ caps_q;
  assign push_data = (is_upper_letter(ascii) && !upper) ? ascii + 8'h20 : ascii;

  always_comb begin
    state_d   = state_q;
    shift_l_d = shift_l_q;
    shift_r_d = shift_r_q;
    caps_d    = caps_q;
    push      = 1'b0;
    if (scan_done_tick) begin
      unique case (state_q)
        StIdle: begin
          if (scan_code == SC_BREAK)       state_d   = StBreak;
          else if (scan_code == SC_EXT)    state_d   = StExt;
          else if (scan_code == SC_LSHIFT) shift_l_d = 1'b1;
          else if (scan_code == SC_RSHIFT) shift_r_d = 1'b1;
          else if (scan_code == SC_CAPS)   caps_d    = ~caps_q;
          else                             push      = (ascii != ASCII_UNMAPPED);
        end
        StBreak: begin
          if (scan_code == SC_LSHIFT) shift_l_d = 1'b0;
          if (scan_code == SC_RSHIFT) shift_r_d = 1'b0;
          state_d = StIdle;
        end
        StExt:      state_d = (scan_code == SC_BREAK) ? StExtBreak : StIdle;
        StExtBreak: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      shift_l_q <= 1'b0;
      shift_r_q <= 1'b0;
      caps_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_l_q <= shift_l_d;
      shift_r_q <= shift_r_d;
      caps_q    <= caps_d;
    end
  end

  char_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_char_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (char_rd),
    .head_o      (char_data),
    .valid_o     (char_valid),
    .overflow_o  (overflow)
  );

  assign caps_lock = caps_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Self-checking bench: per-cycle comparison against a queue-based keyboard model plus literal checks.
module tb_ps2_key_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_done_tick = 1'b0;
  logic       char_rd = 1'b0;
  logic [7:0] char_data;
  logic       char_valid, caps_lock, overflow;

  int checks = 0;
  int errors = 0;

  ps2_key_sequencer #(
    .FIFO_AW (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .scan_code      (scan_code),
    .scan_done_tick (scan_done_tick),
    .char_rd        (char_rd),
    .char_data      (char_data),
    .char_valid     (char_valid),
    .caps_lock      (caps_lock),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  // Model state: expected FIFO contents and keyboard modifiers.
  logic [7:0] m_q [$];
  logic [7:0] m_last;
  logic       m_ovf, m_shl, m_shr, m_caps;
  int         m_prefix;  // 0 none, 1 after F0, 2 after E0, 3 after E0 F0
  logic [7:0] lower_tbl [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_last = 8'h00; m_ovf = 1'b0;
    m_shl = 1'b0; m_shr = 1'b0; m_caps = 1'b0; m_prefix = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) lower_tbl[i] = 8'h2A;
    lower_tbl[8'h1C] = "a"; lower_tbl[8'h32] = "b"; lower_tbl[8'h16] = "1";
    lower_tbl[8'h45] = "0"; lower_tbl[8'h29] = " "; lower_tbl[8'h5A] = 8'h0D;
    lower_tbl[8'h66] = 8'h08;
    model_clear();
    forever begin
      @(posedge clk);
      if (!reset_n) model_clear();
      else begin
        logic       push, pop;
        logic [7:0] ch;
        push = 1'b0; ch = 8'h00;
        if (scan_done_tick) begin
          if (m_prefix == 1) begin
            if (scan_code == 8'h12) m_shl = 1'b0;
            if (scan_code == 8'h59) m_shr = 1'b0;
            m_prefix = 0;
          end else if (m_prefix == 2) m_prefix = (scan_code == 8'hF0) ? 3 : 0;
          else if (m_prefix == 3) m_prefix = 0;
          else if (scan_code == 8'hF0) m_prefix = 1;
          else if (scan_code == 8'hE0) m_prefix = 2;
          else if (scan_code == 8'h12) m_shl = 1'b1;
          else if (scan_code == 8'h59) m_shr = 1'b1;
          else if (scan_code == 8'h58) m_caps = ~m_caps;
          else if (lower_tbl[scan_code] != 8'h2A) begin
            push = 1'b1;
            ch   = lower_tbl[scan_code];
            if (ch >= "a" && ch <= "z" && ((m_shl | m_shr) ^ m_caps)) ch = ch - 8'h20;
          end
        end
        pop   = char_rd && (m_q.size() != 0);
        m_ovf = 1'b0;
        if (m_q.size() != 0) m_last = m_q[0];
        if (pop) void'(m_q.pop_front());
        if (push) begin
          if (m_q.size() < 4) m_q.push_back(ch);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison, mid-cycle away from the sampling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("valid", char_valid, m_q.size() != 0);
        chk("data", char_data, (m_q.size() != 0) ? m_q[0] : m_last);
        chk("caps", caps_lock, m_caps);
        chk("overflow", overflow, m_ovf);
      end
    end
  end

  task automatic send(input logic [7:0] code);
    scan_code = code; scan_done_tick = 1'b1;
    @(posedge clk); #1;
    scan_done_tick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pop_expect(input string name, input logic [7:0] val);
    chk({name, "_valid"}, char_valid, 1'b1);
    chk({name, "_data"}, char_data, val);
    char_rd = 1'b1;
    @(posedge clk); #1;
    char_rd = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", char_valid, 1'b0);
    chk("rst_data", char_data, 8'h00);
    chk("rst_caps", caps_lock, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Make, break: single lowercase entry visible right after the make edge.
    scan_code = 8'h1C; scan_done_tick = 1'b1;
    @(posedge clk); #1;
    scan_done_tick = 1'b0;
    chk("t1_valid_latency", char_valid, 1'b1);
    chk("t1_data_latency", char_data, 8'h61);
    @(posedge clk); #1;
    send(8'hF0); send(8'h1C);
    chk("t1_model_size", m_q.size(), 1);
    pop_expect("t1_a", 8'h61);
    chk("t1_empty", char_valid, 1'b0);
    chk("t1_hold", char_data, 8'h61);

    // Shift press/release.
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
    pop_expect("t2_A", 8'h41);
    pop_expect("t2_a", 8'h61);

    // Caps lock, digit unaffected, shift XOR caps.
    send(8'h58); send(8'hF0); send(8'h58); send(8'h1C); send(8'h16);
    chk("t3_caps_on", caps_lock, 1'b1);
    send(8'h12); send(8'h1C);
    pop_expect("t3_A", 8'h41);
    pop_expect("t3_1", 8'h31);
    pop_expect("t3_a", 8'h61);
    send(8'hF0); send(8'h12); send(8'h58);
    chk("t3_caps_off", caps_lock, 1'b0);

    // Extended and unmapped codes produce nothing.
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'h05);
    chk("t4_empty", char_valid, 1'b0);
    chk("t4_model_size", m_q.size(), 0);

    // Non-letters ignore shift.
    send(8'h12); send(8'h29); send(8'h5A); send(8'h66); send(8'hF0); send(8'h12);
    pop_expect("t5_space", 8'h20);
    pop_expect("t5_cr", 8'h0D);
    pop_expect("t5_bs", 8'h08);

    // Fill to four, fifth drops with an overflow pulse.
    repeat (4) send(8'h1C);
    scan_code = 8'h1C; scan_done_tick = 1'b1;
    @(posedge clk); #1;
    scan_done_tick = 1'b0;
    chk("t6_ovf_pulse", overflow, 1'b1);
    @(posedge clk); #1;
    chk("t6_ovf_clear", overflow, 1'b0);
    chk("t6_model_full", m_q.size(), 4);
    // Fifth with simultaneous pop: both succeed.
    scan_code = 8'h32; scan_done_tick = 1'b1; char_rd = 1'b1;
    @(posedge clk); #1;
    scan_done_tick = 1'b0; char_rd = 1'b0;
    chk("t6_no_ovf", overflow, 1'b0);
    chk("t6_still_full", m_q.size(), 4);
    pop_expect("t6_a0", 8'h61);
    pop_expect("t6_a1", 8'h61);
    pop_expect("t6_a2", 8'h61);
    pop_expect("t6_b", 8'h62);
    chk("t6_empty", char_valid, 1'b0);
    char_rd = 1'b1;  // pop on empty is a no-op
    @(posedge clk); #1;
    char_rd = 1'b0;
    chk("t6_empty_pop", char_valid, 1'b0);

    // Reset mid-sequence after F0 (with caps on) returns to idle.
    send(8'h58); send(8'hF0);
    do_reset();
    send(8'h1C);
    chk("t7_caps", caps_lock, 1'b0);
    pop_expect("t7_a", 8'h61);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
